// File: rtl/ex_muldiv_ctrl_if.sv
// Pipeline-to-multiply/divide unit bundle: operation request, MTHI/MTLO
// writes, flush, and the HI/LO/status outputs back to the pipeline.
`timescale 1ns/1ps

interface ex_muldiv_ctrl_if;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        hi_we_i;
    logic        lo_we_i;
    logic [31:0] wdata_i;
    logic        flush_i;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        busy_o;
    logic        stall_o;
    logic        done_o;

    modport master (
        output start_i, op_i, a_i, b_i, hi_we_i, lo_we_i, wdata_i, flush_i,
        input  hi_o, lo_o, busy_o, stall_o, done_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, hi_we_i, lo_we_i, wdata_i, flush_i,
        output hi_o, lo_o, busy_o, stall_o, done_o
    );
endinterface

// File: rtl/ex_muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers: 32 radix-2 steps on
// operand magnitudes, then one sign-fixup cycle. Fixed 34-cycle latency.
`timescale 1ns/1ps

module ex_muldiv_ctrl (
    input logic             clk_i,
    input logic             rst_i,
    ex_muldiv_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FIX
    } state_t;

    state_t      state;
    logic [4:0]  count;
    logic [1:0]  op_q;
    logic [31:0] opnd_q;
    logic [31:0] acc_hi;
    logic [31:0] acc_lo;
    logic [31:0] a_orig;
    logic        sign_a;
    logic        sign_b;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;

    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        start_ok;
    logic [32:0] mul_sum;
    logic [32:0] div_trial;
    logic [63:0] prod_fix;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    always_comb begin
        a_neg    = ~bus.op_i[0] & bus.a_i[31];
        b_neg    = ~bus.op_i[0] & bus.b_i[31];
        mag_a    = a_neg ? -bus.a_i : bus.a_i;
        mag_b    = b_neg ? -bus.b_i : bus.b_i;
        start_ok = bus.start_i & ~bus.flush_i & (state == IDLE);

        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_q} : 33'd0);
        div_trial = {acc_hi, acc_lo[31]} - {1'b0, opnd_q};

        prod_fix = {acc_hi, acc_lo};
        res_hi   = acc_hi;
        res_lo   = acc_lo;
        if (op_q[1]) begin
            // Divide by zero bypasses sign fixup and reports the raw dividend.
            if (opnd_q == '0) begin
                res_hi = a_orig;
                res_lo = '1;
            end else begin
                res_hi = sign_a ? -acc_hi : acc_hi;
                res_lo = (sign_a ^ sign_b) ? -acc_lo : acc_lo;
            end
        end else begin
            if (sign_a ^ sign_b)
                prod_fix = -{acc_hi, acc_lo};
            res_hi = prod_fix[63:32];
            res_lo = prod_fix[31:0];
        end

        bus.hi_o    = hi_q;
        bus.lo_o    = lo_q;
        bus.done_o  = done_q;
        bus.busy_o  = (state != IDLE);
        bus.stall_o = ~rst_i & ((state != IDLE) | start_ok);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            count  <= '0;
            op_q   <= '0;
            opnd_q <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            a_orig <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.hi_we_i)
                        hi_q <= bus.wdata_i;
                    if (bus.lo_we_i)
                        lo_q <= bus.wdata_i;
                    if (start_ok) begin
                        // Multiply: acc_lo holds the multiplier; divide: the dividend.
                        op_q   <= bus.op_i;
                        opnd_q <= bus.op_i[1] ? mag_b : mag_a;
                        acc_hi <= '0;
                        acc_lo <= bus.op_i[1] ? mag_a : mag_b;
                        a_orig <= bus.a_i;
                        sign_a <= a_neg;
                        sign_b <= b_neg;
                        count  <= '0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.flush_i) begin
                        state <= IDLE;
                    end else begin
                        if (op_q[1]) begin
                            if (!div_trial[32]) begin
                                acc_hi <= div_trial[31:0];
                                acc_lo <= {acc_lo[30:0], 1'b1};
                            end else begin
                                acc_hi <= {acc_hi[30:0], acc_lo[31]};
                                acc_lo <= {acc_lo[30:0], 1'b0};
                            end
                        end else begin
                            {acc_hi, acc_lo} <= {mul_sum, acc_lo[31:1]};
                        end
                        count <= count + 5'd1;
                        if (count == 5'd31)
                            state <= FIX;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    if (!bus.flush_i) begin
                        hi_q   <= res_hi;
                        lo_q   <= res_lo;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Self-checking bench for ex_muldiv_ctrl: directed corner cases plus random
// operations compared against a plain-arithmetic HI/LO reference model.
`timescale 1ns/1ps

module tb_ex_muldiv_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    ex_muldiv_ctrl_if bus ();

    ex_muldiv_ctrl dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.start_i = 1'b0;
        bus.op_i    = '0;
        bus.a_i     = '0;
        bus.b_i     = '0;
        bus.hi_we_i = 1'b0;
        bus.lo_we_i = 1'b0;
        bus.wdata_i = '0;
        bus.flush_i = 1'b0;
    endtask

    // Noise the pipeline might present while the unit is busy; all of it must be ignored.
    task automatic garbage_inputs();
        bus.start_i = 1'($urandom_range(0, 1));
        bus.op_i    = 2'($urandom_range(0, 3));
        bus.a_i     = $urandom;
        bus.b_i     = $urandom;
        bus.hi_we_i = 1'($urandom_range(0, 1));
        bus.lo_we_i = 1'($urandom_range(0, 1));
        bus.wdata_i = $urandom;
        bus.flush_i = 1'b0;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    // Returns {hi, lo} as the architecture defines it.
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == 2'b00) begin
            res = sa * sb;
        end else if (op == 2'b01) begin
            res = {32'd0, a} * {32'd0, b};
        end else if (b == 32'd0) begin
            res = {a, 32'hFFFF_FFFF};
        end else if (op == 2'b10) begin
            q = sa / sb;
            r = sa % sb;
            res = {r[31:0], q[31:0]};
        end else begin
            res = {a % b, a / b};
        end
        return res;
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit mt, input string tag);
        logic [63:0] exp;
        logic [31:0] w;
        int cyc;
        int stall_low;
        exp = ref_result(op, a, b);
        w = $urandom;
        clear_inputs();
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        if (mt) begin
            bus.hi_we_i = 1'b1;
            bus.lo_we_i = 1'b1;
            bus.wdata_i = w;
        end
        #1;
        check_eq({tag, " stall_at_start"}, 64'(bus.stall_o), 64'd1);
        tick();
        if (mt)
            check_eq({tag, " mt_with_start"}, {bus.hi_o, bus.lo_o}, {w, w});
        cyc = 1;
        stall_low = 0;
        while (!bus.done_o && cyc < 40) begin
            if (!bus.stall_o || !bus.busy_o)
                stall_low++;
            garbage_inputs();
            tick();
            cyc++;
        end
        check_eq({tag, " latency"}, 64'(cyc), 64'd34);
        check_eq({tag, " stall_busy_low_cycles"}, 64'(stall_low), 64'd0);
        clear_inputs();
        #1;
        check_eq({tag, " stall_busy_in_done"}, {62'd0, bus.stall_o, bus.busy_o}, 64'd0);
        check_eq({tag, " result"}, {bus.hi_o, bus.lo_o}, exp);
        model_hi = exp[63:32];
        model_lo = exp[31:0];
        tick();
        check_eq({tag, " done_one_cycle"}, 64'(bus.done_o), 64'd0);
    endtask

    // Start an operation, then abort in cycle k (flush or reset) and verify no completion.
    task automatic abort_at(input int k, input bit use_rst, input logic [1:0] op,
                            input logic [31:0] a, input logic [31:0] b, input string tag);
        int dones;
        clear_inputs();
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        tick();
        for (int i = 1; i < k; i++) begin
            garbage_inputs();
            tick();
        end
        clear_inputs();
        if (use_rst) begin
            rst = 1'b1;
            model_hi = '0;
            model_lo = '0;
        end else begin
            bus.flush_i = 1'b1;
        end
        tick();
        check_eq({tag, " busy_done_stall"}, {61'd0, bus.busy_o, bus.done_o, bus.stall_o}, 64'd0);
        check_eq({tag, " hilo"}, {bus.hi_o, bus.lo_o}, {model_hi, model_lo});
        rst = 1'b0;
        bus.flush_i = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done_o)
                dones++;
            tick();
        end
        check_eq({tag, " no_done"}, 64'(dones), 64'd0);
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        bus.start_i = 1'b1;
        bus.hi_we_i = 1'b1;
        bus.lo_we_i = 1'b1;
        bus.wdata_i = 32'hDEAD_BEEF;
        bus.flush_i = 1'b1;
        #1;
        check_eq("stall_in_reset", 64'(bus.stall_o), 64'd0);
        tick();
        tick();
        check_eq("reset_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
        check_eq("reset_busy_done", {62'd0, bus.busy_o, bus.done_o}, 64'd0);
        rst = 1'b0;
        clear_inputs();
        tick();

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, "mult_neg3x7");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg7by2");
        run_op(2'b11, 32'd100, 32'd7, 1'b0, "divu_100by7");
        run_op(2'b11, 32'h1234_5678, 32'd0, 1'b0, "divu_by0");
        run_op(2'b10, 32'hFFFF_FFFB, 32'd0, 1'b0, "div_neg_by0");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_overflow");
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b1, "mult_minmin");

        // MTHI in idle, then flush mid-multiply keeps it.
        clear_inputs();
        bus.hi_we_i = 1'b1;
        bus.wdata_i = 32'hA5A5_A5A5;
        tick();
        clear_inputs();
        model_hi = 32'hA5A5_A5A5;
        check_eq("mthi_idle", 64'(bus.hi_o), 64'h0000_0000_A5A5_A5A5);
        abort_at(10, 1'b0, 2'b00, 32'h0001_2345, 32'hFFFF_0001, "flush_busy");
        abort_at(33, 1'b0, 2'b11, 32'h0000_0100, 32'd3, "flush_fix");

        // Flush in idle blocks start but not MTLO.
        clear_inputs();
        bus.start_i = 1'b1;
        bus.flush_i = 1'b1;
        bus.lo_we_i = 1'b1;
        bus.wdata_i = 32'h0BAD_F00D;
        #1;
        check_eq("flush_idle_stall", 64'(bus.stall_o), 64'd0);
        tick();
        clear_inputs();
        model_lo = 32'h0BAD_F00D;
        check_eq("flush_idle_busy", 64'(bus.busy_o), 64'd0);
        check_eq("flush_idle_mtlo", {bus.hi_o, bus.lo_o}, {model_hi, model_lo});

        abort_at(20, 1'b1, 2'b11, 32'hCAFE_0000, 32'd9, "rst_mid_divu");
        run_op(2'b11, 32'hCAFE_0000, 32'd9, 1'b0, "divu_after_rst");

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                clear_inputs();
                bus.hi_we_i = 1'($urandom_range(0, 1));
                bus.lo_we_i = 1'($urandom_range(0, 1));
                bus.flush_i = 1'($urandom_range(0, 1));
                bus.wdata_i = $urandom;
                if (bus.hi_we_i)
                    model_hi = bus.wdata_i;
                if (bus.lo_we_i)
                    model_lo = bus.wdata_i;
                tick();
                clear_inputs();
                check_eq("rand_mt_idle", {bus.hi_o, bus.lo_o}, {model_hi, model_lo});
            end
            run_op(2'($urandom_range(0, 3)), rand_operand(), rand_operand(),
                   bit'($urandom_range(0, 1)), "rand_op");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_muldiv_ctrl.md
EX_MULDIV_CTRL -- requirements
Module: ex_muldiv_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk_i (input, 1, rising-edge clock) and rst_i (input, 1, synchronous active-high reset).
REQ-002 It SHALL have the following inputs:
- start_i, 1 bit: request a multiply or divide, sampled in IDLE.
- op_i, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a_i, 32 bits: rs operand (multiplicand or dividend).
- b_i, 32 bits: rt operand (multiplier or divisor).
- hi_we_i, 1 bit: MTHI write enable.
- lo_we_i, 1 bit: MTLO write enable.
- wdata_i, 32 bits: MTHI/MTLO data.
- flush_i, 1 bit: abort the operation in flight.
REQ-003 It SHALL have the following outputs:
- hi_o, 32 bits: HI register.
- lo_o, 32 bits: LO register.
- busy_o, 1 bit: operation in flight.
- stall_o, 1 bit: freeze the IF/ID/EX pipeline.
- done_o, 1 bit: one-cycle completion pulse.

Function
REQ-004 The block SHALL use a three-state FSM: IDLE, BUSY, FIX.
REQ-005 In IDLE, start_i=1 and flush_i=0 SHALL latch op_i, |a_i|, |b_i| (magnitudes for signed ops), the operand signs and the original a_i, then go to BUSY with count=0.
REQ-006 BUSY SHALL perform one radix-2 step per cycle (shift-add for multiply, restoring shift-subtract for divide); after count=31 it SHALL go to FIX.
REQ-007 FIX SHALL apply sign correction, write hi_o/lo_o at the edge leaving FIX, and return to IDLE.
REQ-008 Latency SHALL be fixed: start sampled at edge T gives BUSY in T+1..T+32, FIX in T+33, and hi_o/lo_o valid with done_o=1 in T+34.
REQ-009 Multiply SHALL produce the 64-bit product {hi,lo}; MULT is signed and MULTU unsigned.
REQ-010 Divide SHALL produce lo=quotient and hi=remainder; DIV truncates toward zero and the remainder takes the sign of the dividend.
REQ-011 Divide by zero SHALL complete with normal latency and give lo=32'hFFFF_FFFF and hi=the original a_i.
REQ-012 DIV 32'h8000_0000 / 32'hFFFF_FFFF SHALL give lo=32'h8000_0000 and hi=0.
REQ-013 busy_o SHALL equal (state != IDLE) and be decoded from registered state only.
REQ-014 stall_o SHALL equal busy_o | (start_i & state==IDLE & ~flush_i), combinationally; it is low in the done_o cycle.
REQ-015 done_o SHALL be registered, high for exactly one cycle per completed operation, and never high after an aborted operation.
REQ-016 In IDLE, hi_we_i/lo_we_i SHALL load wdata_i into HI/LO at the next edge.
REQ-017 An MTHI/MTLO write together with start_i SHALL apply, and the later result SHALL overwrite it.
REQ-018 hi_we_i/lo_we_i SHALL be ignored while busy_o=1.
REQ-019 flush_i in BUSY or FIX SHALL return to IDLE at the next edge, leave HI/LO unchanged and suppress done_o.
REQ-020 flush_i in IDLE SHALL block start_i and SHALL NOT block MTHI/MTLO writes.
REQ-021 start_i while busy_o=1 SHALL be ignored; the pipeline holds it, since stall_o=1.
REQ-022 The iteration counter SHALL be 5 bits, and count=31 SHALL be the terminal step with no wrap into a 33rd step.

Reset
REQ-023 When rst_i=1 at an edge, the block SHALL set: state=IDLE, count=0, hi_o=0, lo_o=0, busy_o=0, done_o=0, and clear all operand/sign registers.
REQ-024 rst_i SHALL override flush_i, start_i and MTHI/MTLO writes in the same cycle.
REQ-025 rst_i mid-operation SHALL abort the operation with no done_o.
REQ-026 While rst_i=1, stall_o SHALL be 0.

Verification
REQ-027 MULTU: a=32'hFFFF_FFFF, b=32'hFFFF_FFFF, start at T -> done_o at T+34 with hi=32'hFFFF_FFFE, lo=32'h0000_0001; stall_o high T..T+33.
REQ-028 MULT: a=-3 (32'hFFFF_FFFD), b=7 -> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB.
REQ-029 DIV: a=-7, b=2 -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF; DIVU a=100, b=7 -> lo=14, hi=2.
REQ-030 DIVU: a=32'h1234_5678, b=0 -> lo=32'hFFFF_FFFF, hi=32'h1234_5678 at T+34.
REQ-031 MTHI of 32'hA5A5_A5A5 in IDLE, then a MULT start, then flush_i at T+10 -> IDLE at T+11, hi=32'hA5A5_A5A5, no done_o.
REQ-032 rst_i at T+20 during DIVU -> all outputs 0 at T+21; start_i issued again completes normally with correct result.
